// File: rtl/md_sequencer.sv
// Multi-cycle sequencer for the E-stage multiply/divide unit driving HI/LO and busy.
// Define MD_MADD_EN to add MADD (op 6) and MADDU (op 7) accumulate operations.
module md_sequencer #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        cancel,
   output logic        busy,
   output logic        done,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   typedef enum logic {IDLE, RUN} state_t;

   localparam logic [3:0] MULT_CNT = 4'(MULT_CYCLES);
   localparam logic [3:0] DIV_CNT  = 4'(DIV_CYCLES);

   state_t      state, state_next;
   logic [3:0]  cnt, cnt_next;
   logic [31:0] res_hi, res_lo;
   logic        commit_en;
   logic        madd_q;
   logic        commit;
   logic        accept;
   logic        is_mult, is_div, is_mthi, is_mtlo, is_madd, op_legal;

   logic [63:0] sa64, sb64, sbs64;
   logic [63:0] prod_s, prod_u;
   logic [31:0] b_safe, q_s, r_s, q_u, r_u;

   always_comb begin
      is_mult = (op == 3'd0) || (op == 3'd1);
      is_div  = (op == 3'd2) || (op == 3'd3);
      is_mthi = (op == 3'd4);
      is_mtlo = (op == 3'd5);
`ifdef MD_MADD_EN
      is_madd = (op == 3'd6) || (op == 3'd7);
`else
      is_madd = 1'b0;
`endif
      op_legal = is_mult | is_div | is_mthi | is_mtlo | is_madd;
   end

   assign accept = start & ~cancel & (state == IDLE) & op_legal;
   assign busy   = (state == RUN);

   // Divide in 64 bits so 0x80000000 / -1 cannot overflow; a zero divisor is
   // replaced by 1 only to keep the arithmetic defined, its result is discarded.
   always_comb begin
      b_safe = (b == 32'd0) ? 32'd1 : b;
      sa64   = {{32{a[31]}}, a};
      sb64   = {{32{b[31]}}, b};
      sbs64  = {{32{b_safe[31]}}, b_safe};
      prod_s = $signed(sa64) * $signed(sb64);
      prod_u = {32'd0, a} * {32'd0, b};
      q_s    = 32'($signed(sa64) / $signed(sbs64));
      r_s    = 32'($signed(sa64) % $signed(sbs64));
      q_u    = a / b_safe;
      r_u    = a % b_safe;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= 4'd0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
      end
   end

   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      commit     = 1'b0;
      case (state)
         IDLE: begin
            if (accept && (is_mult || is_div || is_madd)) begin
               state_next = RUN;
               cnt_next   = is_div ? DIV_CNT : MULT_CNT;
            end
         end
         RUN: begin
            cnt_next = cnt - 4'd1;
            if (cnt == 4'd1) begin
               commit     = 1'b1;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Results are captured at acceptance; MADD folds into HI/LO as they stand at commit.
   always_ff @(posedge clk) begin
      if (reset) begin
         done      <= 1'b0;
         hi        <= 32'd0;
         lo        <= 32'd0;
         res_hi    <= 32'd0;
         res_lo    <= 32'd0;
         commit_en <= 1'b0;
         madd_q    <= 1'b0;
      end else begin
         done <= commit;
         if (accept) begin
            if (is_mthi) hi <= a;
            if (is_mtlo) lo <= a;
            if (is_div)
               {res_hi, res_lo} <= op[0] ? {r_u, q_u} : {r_s, q_s};
            else
               {res_hi, res_lo} <= op[0] ? prod_u : prod_s;
            commit_en <= !(is_div && (b == 32'd0));
            madd_q    <= is_madd;
         end
         if (commit) begin
            if (madd_q)
               {hi, lo} <= {hi, lo} + {res_hi, res_lo};
            else if (commit_en)
               {hi, lo} <= {res_hi, res_lo};
         end
      end
   end

endmodule

// File: tb/tb_md_sequencer.sv
// Scoreboard bench for md_sequencer: directed cases then random traffic against a longint model.
module tb_md_sequencer;

   localparam int MULT_N = 5;
   localparam int DIV_N  = 10;
`ifdef MD_MADD_EN
   localparam bit MADD_EN = 1'b1;
`else
   localparam bit MADD_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic        cancel = 1'b0;
   logic [2:0]  op = 3'd0;
   logic [31:0] a = 32'd0;
   logic [31:0] b = 32'd0;
   logic        busy, done;
   logic [31:0] hi, lo;

   md_sequencer #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
      .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
      .cancel(cancel), .busy(busy), .done(done), .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
   } exp_t;

   exp_t        exp_q[$];
   int          edge_cnt = 0;
   int          busy_from = 0, busy_to = 0, done_at = -1, free_edge = 0;
   int          n_checks = 0, n_fail = 0;
   bit          checking = 1'b0;
   logic [31:0] model_hi = 32'd0, model_lo = 32'd0;

   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_checks++;
      if (act !== expv) begin
         n_fail++;
         $display("[TB] FAIL %s: got %h, expected %h (edge %0d)", name, act, expv, edge_cnt);
      end
   endtask

   // Architectural result of one operation on the current HI/LO pair.
   function automatic void modelResult(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                                       inout logic [31:0] h, inout logic [31:0] l);
      longint          sx, sy, q;
      longint unsigned ux, uy, p;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      ux = {32'd0, x};
      uy = {32'd0, y};
      case (o)
         3'd0: begin p = sx * sy; {h, l} = p; end
         3'd1: begin p = ux * uy; {h, l} = p; end
         3'd2: if (y != 0) begin q = sx / sy; l = q[31:0]; q = sx - q * sy; h = q[31:0]; end
         3'd3: if (y != 0) begin p = ux / uy; l = p[31:0]; p = ux - p * uy; h = p[31:0]; end
         3'd4: h = x;
         3'd5: l = x;
         default: if (MADD_EN) begin
            p = (o == 3'd6) ? longint'(sx * sy) : ux * uy;
            p = {h, l} + p;
            {h, l} = p;
         end
      endcase
   endfunction

   task automatic stepCycles(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic waitIdle();
      while (edge_cnt < free_edge) stepCycles(1);
   endtask

   task automatic doReset();
      reset = 1'b1;
      start = 1'b0;
      cancel = 1'b0;
      stepCycles(1);
      reset = 1'b0;
      model_hi = 32'd0;
      model_lo = 32'd0;
      exp_q.delete();
      busy_from = 0;
      busy_to = 0;
      done_at = -1;
      free_edge = edge_cnt + 1;
   endtask

   // Drive one cycle of inputs and let the model decide whether it was taken.
   task automatic applyStimulus(input bit st, input logic [2:0] o, input logic [31:0] x,
                                input logic [31:0] y, input bit c);
      int   e, lat;
      bit   legal, is_long;
      exp_t r;
      start = st; op = o; a = x; b = y; cancel = c;
      stepCycles(1);
      e = edge_cnt;
      start = 1'b0;
      cancel = 1'b0;
      legal   = (o <= 3'd5) || MADD_EN;
      is_long = (o <= 3'd3) || (o >= 3'd6);
      if (st && !c && legal && e >= free_edge) begin
         modelResult(o, x, y, model_hi, model_lo);
         if (is_long) begin
            lat = (o == 3'd2 || o == 3'd3) ? DIV_N : MULT_N;
            r.hi = model_hi;
            r.lo = model_lo;
            exp_q.push_back(r);
            busy_from = e;
            busy_to   = e + lat;
            done_at   = e + lat;
            free_edge = e + lat + 1;
         end
      end
   endtask

   // Monitor: busy/done against the model timeline, HI/LO popped from the scoreboard on done.
   always @(negedge clk) begin
      exp_t r;
      if (checking && !reset) begin
         checkOutput("busy", {31'd0, busy}, {31'd0, (edge_cnt >= busy_from && edge_cnt < busy_to)});
         checkOutput("done", {31'd0, done}, {31'd0, (edge_cnt == done_at)});
         if (done === 1'b1) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("[TB] FAIL done_unexpected: got done=1, expected no commit (edge %0d)", edge_cnt);
            end else begin
               r = exp_q.pop_front();
               checkOutput("commit_hi", hi, r.hi);
               checkOutput("commit_lo", lo, r.lo);
            end
         end
      end
   end

   initial begin
      logic [2:0]  ro;
      logic [31:0] rx, ry;
      bit          rc;

      doReset();
      checking = 1'b1;
      checkOutput("reset_hi", hi, 32'd0);
      checkOutput("reset_lo", lo, 32'd0);
      checkOutput("reset_busy", {31'd0, busy}, 32'd0);
      checkOutput("reset_done", {31'd0, done}, 32'd0);

      applyStimulus(1, 3'd0, 32'hFFFFFFFE, 32'd3, 0);
      waitIdle();
      checkOutput("mult_hi", hi, 32'hFFFFFFFF);
      checkOutput("mult_lo", lo, 32'hFFFFFFFA);

      applyStimulus(1, 3'd1, 32'hFFFFFFFF, 32'd2, 0);
      waitIdle();
      checkOutput("multu_hi", hi, 32'h00000001);
      checkOutput("multu_lo", lo, 32'hFFFFFFFE);

      applyStimulus(1, 3'd2, 32'hFFFFFFF9, 32'd2, 0);
      waitIdle();
      checkOutput("div_hi", hi, 32'hFFFFFFFF);
      checkOutput("div_lo", lo, 32'hFFFFFFFD);

      applyStimulus(1, 3'd4, 32'h11, 32'd0, 0);
      applyStimulus(1, 3'd5, 32'h22, 32'd0, 0);
      applyStimulus(1, 3'd3, 32'd7, 32'd0, 0);
      waitIdle();
      checkOutput("div0_hi", hi, 32'h11);
      checkOutput("div0_lo", lo, 32'h22);

      applyStimulus(1, 3'd0, 32'd3, 32'd4, 1);
      stepCycles(2);
      checkOutput("cancel_busy", {31'd0, busy}, 32'd0);
      checkOutput("cancel_hi", hi, 32'h11);

      applyStimulus(1, 3'd0, 32'd3, 32'd4, 0);
      applyStimulus(1, 3'd4, 32'd5, 32'd0, 0);
      applyStimulus(0, 3'd0, 32'd0, 32'd0, 1);
      applyStimulus(0, 3'd0, 32'd0, 32'd0, 1);
      waitIdle();
      checkOutput("inrun_hi", hi, 32'd0);
      checkOutput("inrun_lo", lo, 32'd12);

      applyStimulus(1, 3'd2, 32'd100, 32'd7, 0);
      stepCycles(2);
      doReset();
      checkOutput("abort_busy", {31'd0, busy}, 32'd0);
      checkOutput("abort_hi", hi, 32'd0);
      checkOutput("abort_lo", lo, 32'd0);
      applyStimulus(1, 3'd0, 32'd6, 32'd7, 0);
      waitIdle();
      checkOutput("postreset_lo", lo, 32'd42);

      applyStimulus(1, 3'd2, 32'h80000000, 32'hFFFFFFFF, 0);
      waitIdle();
      checkOutput("ovf_hi", hi, 32'd0);
      checkOutput("ovf_lo", lo, 32'h80000000);

      applyStimulus(1, 3'd4, 32'd0, 32'd0, 0);
      applyStimulus(1, 3'd5, 32'hFFFFFFFF, 32'd0, 0);
      applyStimulus(1, 3'd7, 32'd1, 32'd1, 0);
      waitIdle();
      checkOutput("maddu_hi", hi, MADD_EN ? 32'd1 : 32'd0);
      checkOutput("maddu_lo", lo, MADD_EN ? 32'd0 : 32'hFFFFFFFF);

      for (int i = 0; i < 150; i++) begin
         ro = 3'($urandom_range(0, 7));
         rx = $urandom;
         ry = $urandom;
         case ($urandom_range(0, 7))
            0: ry = 32'd0;
            1: begin rx = 32'h80000000; ry = 32'hFFFFFFFF; end
            2: ry = 32'($urandom_range(1, 9));
            default: ;
         endcase
         rc = ($urandom_range(0, 7) == 0);
         if ($urandom_range(0, 49) == 0) doReset();
         applyStimulus(1, ro, rx, ry, rc);
         for (int j = $urandom_range(0, 6); j > 0; j--)
            applyStimulus($urandom_range(0, 3) == 0, 3'($urandom_range(0, 7)), $urandom, $urandom,
                          $urandom_range(0, 3) == 0);
         if ($urandom_range(0, 3) == 0) begin
            waitIdle();
            checkOutput("rand_hi", hi, model_hi);
            checkOutput("rand_lo", lo, model_lo);
         end
      end

      waitIdle();
      stepCycles(2);
      checkOutput("final_hi", hi, model_hi);
      checkOutput("final_lo", lo, model_lo);
      checkOutput("scoreboard_empty", 32'(exp_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/md_sequencer.md
Name: md_sequencer

Overview:
- Sequencing controller for the E-stage multiply/divide resource.
- Accepts one HI/LO operation per start pulse and models the multi-cycle latency of MULT/DIV with a down-counter.
- Drives busy to the hazard unit and commits results to the HI/LO architectural registers.
- Suppresses new operations in the cycle an exception/interrupt entry is signalled.

Parameters:
- MULT_CYCLES, 5, cycles busy stays high for MULT/MULTU (legal range 1..15).
- DIV_CYCLES, 10, cycles busy stays high for DIV/DIVU (legal range 1..15).

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- start  input  1  E-stage HI/LO instruction valid this cycle
- op  input  3  0=MULT 1=MULTU 2=DIV 3=DIVU 4=MTHI 5=MTLO; 6/7 reserved (see optional feature)
- a  input  32  forwarded rs operand
- b  input  32  forwarded rt operand
- cancel  input  1  exception/interrupt entry this cycle; blocks acceptance
- busy  output  1  operation in flight
- done  output  1  one-cycle pulse when HI/LO are committed by MULT/DIV
- hi  output  32  HI register
- lo  output  32  LO register

Behaviour:
- States: IDLE, RUN. Registered counter cnt, 4 bits. Result holding registers res_hi, res_lo.
- Reset: state=IDLE, cnt=0, busy=0, done=0, hi=0, lo=0, res_hi=res_lo=0.
- Acceptance: start & !cancel & state==IDLE. A start while in RUN, or with cancel=1, is ignored with no state change. The hazard unit guarantees a stall in these cases.
- MULT/MULTU accepted at edge k:
  - res = signed/unsigned 64-bit product of a and b.
  - cnt = MULT_CYCLES; state goes to RUN.
- DIV/DIVU accepted at edge k:
  - res_lo = quotient, res_hi = remainder; signed mode truncates toward zero, remainder takes the dividend's sign.
  - cnt = DIV_CYCLES; state goes to RUN.
  - b==0: still busy for DIV_CYCLES, but hi/lo are left unchanged at completion; done still pulses.
  - Signed 0x80000000 / -1: lo=0x80000000, hi=0.
- RUN:
  - busy=1 combinationally from state, i.e. high for cycles k+1..k+N.
  - Each edge decrements cnt.
  - At the edge where cnt==1: hi=res_hi, lo=res_lo (subject to the div-by-zero rule), state goes to IDLE, done=1 for the following cycle only.
- hi/lo hold their old values during RUN. Reads during RUN are blocked by the hazard unit, not by this block.
- MTHI/MTLO accepted at edge k: hi (or lo) = a at that edge. No busy, no done, state stays IDLE.
- cancel during RUN is ignored: the in-flight operation belongs to an older, committed instruction and completes normally.
- reset mid-RUN: the operation is aborted and everything returns to reset values at that edge.
- done is registered; it is 0 in every cycle except the single cycle after commit.

Optional Feature:
- Macro: MD_MADD_EN.
- Defined:
  - op 6 = MADD: {hi,lo} += signed a*b, modulo 2^64.
  - op 7 = MADDU: {hi,lo} += unsigned a*b, modulo 2^64.
  - The product is computed at acceptance; the add uses the {hi,lo} value at commit.
  - Latency is MULT_CYCLES; done pulses at commit.
- Undefined: op 6/7 are treated as no-ops. They are never accepted, busy stays 0, and hi/lo are unchanged.

Test Plan:
- Reset, then MULT a=0xFFFFFFFE (-2), b=3 -> busy high exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA, done pulses 1 cycle.
- MULTU a=0xFFFFFFFF, b=2 -> after 5 busy cycles hi=0x00000001, lo=0xFFFFFFFE.
- DIV a=-7 (0xFFFFFFF9), b=2 -> busy 10 cycles; lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=7, b=0 with hi/lo preloaded by MTHI 0x11 / MTLO 0x22 -> after 10 busy cycles hi=0x11, lo=0x22, done pulses.
- MULT started with cancel=1 -> busy stays 0, hi/lo unchanged. Start MTHI a=5 during RUN -> ignored, hi shows only the multiply result. cancel asserted mid-RUN -> completion unaffected.
- reset asserted at the 3rd busy cycle of DIV -> next cycle busy=0, hi=lo=0, done never pulses. A new MULT accepted immediately after reset completes normally.
- (MD_MADD_EN) hi=0, lo=0xFFFFFFFF, MADDU a=1, b=1 -> hi=1, lo=0 after 5 cycles. Without the macro the same op leaves hi=0, lo=0xFFFFFFFF and busy=0.
